// File: rtl/shift_reg_pkg.sv
// Mode encodings shared by the bidirectional shift register and its stages.
package shift_reg_pkg;

    localparam int unsigned MODE_W = 2;

    typedef logic [MODE_W-1:0] mode_t;

    localparam mode_t MODE_HOLD = 2'b00;
    localparam mode_t MODE_SHR  = 2'b01;
    localparam mode_t MODE_SHL  = 2'b10;
    localparam mode_t MODE_LOAD = 2'b11;

endpackage

// File: rtl/shift_stage.sv
// One register stage: 4:1 next-value mux (hold/right/left/load) into a flop
// with asynchronous active-low clear.
module shift_stage
    import shift_reg_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  mode_t sel,
    input  logic  right_nb,
    input  logic  left_nb,
    input  logic  load_bit,
    output logic  q
);

    // Unknown or hold select keeps the stored bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            case (sel)
                MODE_SHR:  q <= right_nb;
                MODE_SHL:  q <= left_nb;
                MODE_LOAD: q <= load_bit;
                default:   q <= q;
            endcase
        end
    end

endmodule

// File: rtl/shift_reg_lr.sv
// Parallel-load bidirectional shift register built from WIDTH shift_stage flops.
// Define SHIFT_ROTATE_EN to make both shift modes rotate instead of taking serial inputs.
module shift_reg_lr
    import shift_reg_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       select,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] right_src;
    logic [WIDTH-1:0] left_src;
    logic             right_end;
    logic             left_end;

`ifdef SHIFT_ROTATE_EN
    // Serial inputs are kept on the port list but play no part when rotating.
    logic unused_ser;
    assign unused_ser = ser_in_r ^ ser_in_l;
    assign right_end  = q[0];
    assign left_end   = q[WIDTH-1];
`else
    assign right_end  = ser_in_r;
    assign left_end   = ser_in_l;
`endif

    // Bit i of right_src is stage i+1 (MSB end fed externally); left_src mirrors it.
    assign right_src = {right_end, q[WIDTH-1:1]};
    assign left_src  = {q[WIDTH-2:0], left_end};

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_stage
        shift_stage u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .sel      (mode_t'(select)),
            .right_nb (right_src[i]),
            .left_nb  (left_src[i]),
            .load_bit (data_in[i]),
            .q        (q[i])
        );
    end

    assign data_out = q;

endmodule

// File: tb/tb_shift_reg_lr.sv
// Self-checking bench for shift_reg_lr: scoreboard of expected register contents.
module tb_shift_reg_lr;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic [1:0]   select;
    logic [W-1:0] data_in;
    logic         ser_in_r;
    logic         ser_in_l;
    logic [W-1:0] data_out;

    logic [W-1:0] model_q;
    logic [W-1:0] sb[$];
    logic [W-1:0] exp_v;
    int           vectors;
    int           miscompares;

    shift_reg_lr #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .select   (select),
        .data_in  (data_in),
        .ser_in_r (ser_in_r),
        .ser_in_l (ser_in_l),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] model_next(input logic [W-1:0] q, input logic [1:0] s,
                                                input logic [W-1:0] d, input logic sr,
                                                input logic sl);
        logic [W-1:0] r;
        case (s)
`ifdef SHIFT_ROTATE_EN
            2'b01:   r = {q[0], q[W-1:1]};
            2'b10:   r = {q[W-2:0], q[W-1]};
`else
            2'b01:   r = {sr, q[W-1:1]};
            2'b10:   r = {q[W-2:0], sl};
`endif
            2'b11:   r = d;
            default: r = q;
        endcase
        return r;
    endfunction

    // Drive one cycle's inputs on the falling edge, queue the expected result,
    // and return just after the rising edge that applies them.
    task automatic step(input logic [1:0] s, input logic [W-1:0] d, input logic sr,
                        input logic sl);
        @(negedge clk);
        select   = s;
        data_in  = d;
        ser_in_r = sr;
        ser_in_l = sl;
        model_q  = model_next(model_q, s, d, sr, sl);
        sb.push_back(model_q);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        select = 2'b00; data_in = '0; ser_in_r = 1'b0; ser_in_l = 1'b0;
        model_q = '0;
        #12;
        vectors++;
        if (data_out !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_initial: got %h want %h", data_out, 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(2'b11, 8'hFF, 1'b0, 1'b0);
        exp_v = sb.pop_front();
        vectors++;
        if (data_out !== exp_v) begin
            miscompares++;
            $display("FAIL reset_preload: got %h want %h", data_out, exp_v);
        end
        // Assert reset mid-cycle; clear must not wait for an edge.
        #2;
        rst_n = 1'b0;
        select = 2'b11;
        model_q = '0;
        #1;
        vectors++;
        if (data_out !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_async: got %h want %h", data_out, 8'h00);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (data_out !== 8'h00) begin
                miscompares++;
                $display("FAIL reset_held[%0d]: got %h want %h", i, data_out, 8'h00);
            end
        end
        rst_n = 1'b1;
        step(2'b11, 8'h5A, 1'b0, 1'b0);
        exp_v = sb.pop_front();
        vectors++;
        if (data_out !== exp_v || data_out !== 8'h5A) begin
            miscompares++;
            $display("FAIL reset_first_edge: got %h want %h", data_out, 8'h5A);
        end
    endtask

    task automatic test_load_shift_right();
        step(2'b11, 8'h33, 1'b1, 1'b1);
        exp_v = sb.pop_front();
        vectors++;
        if (data_out !== exp_v) begin
            miscompares++;
            $display("FAIL load_33: got %h want %h", data_out, exp_v);
        end
        step(2'b01, 8'hAA, 1'b0, 1'b1);
        exp_v = sb.pop_front();
        vectors++;
        if (data_out !== exp_v) begin
            miscompares++;
            $display("FAIL shr_33: got %h want %h", data_out, exp_v);
        end
    endtask

    task automatic test_load_shift_left();
        step(2'b11, 8'h33, 1'b0, 1'b0);
        exp_v = sb.pop_front();
        vectors++;
        if (data_out !== exp_v) begin
            miscompares++;
            $display("FAIL shl_load: got %h want %h", data_out, exp_v);
        end
        for (int i = 0; i < 3; i++) begin
            step(2'b10, 8'h0F, 1'b1, 1'b0);
            exp_v = sb.pop_front();
            vectors++;
            if (data_out !== exp_v) begin
                miscompares++;
                $display("FAIL shl_step[%0d]: got %h want %h", i, data_out, exp_v);
            end
        end
    endtask

    task automatic test_hold();
        logic [W-1:0] d;
        step(2'b11, 8'hA5, 1'b0, 1'b0);
        exp_v = sb.pop_front();
        vectors++;
        if (data_out !== exp_v) begin
            miscompares++;
            $display("FAIL hold_load: got %h want %h", data_out, exp_v);
        end
        d = 8'h0F;
        for (int i = 0; i < 5; i++) begin
            step(2'b00, d, 1'b1, 1'b1);
            d = ~d;
            exp_v = sb.pop_front();
            vectors++;
            if (data_out !== exp_v || data_out !== 8'hA5) begin
                miscompares++;
                $display("FAIL hold[%0d]: got %h want %h", i, data_out, 8'hA5);
            end
        end
        // X on select must behave as hold.
        step(2'bxx, 8'h00, 1'b1, 1'b1);
        exp_v = sb.pop_front();
        vectors++;
        if (data_out !== 8'hA5) begin
            miscompares++;
            $display("FAIL hold_x_select: got %h want %h", data_out, 8'hA5);
        end
    endtask

    task automatic test_serial_fill();
        for (int dir = 0; dir < 2; dir++) begin
            step(2'b11, 8'h00, 1'b0, 1'b0);
            exp_v = sb.pop_front();
            vectors++;
            if (data_out !== exp_v) begin
                miscompares++;
                $display("FAIL fill_clear[%0d]: got %h want %h", dir, data_out, exp_v);
            end
            for (int i = 0; i < int'(W); i++) begin
                step((dir == 0) ? 2'b01 : 2'b10, 8'h00, 1'b1, 1'b1);
                exp_v = sb.pop_front();
                vectors++;
                if (data_out !== exp_v) begin
                    miscompares++;
                    $display("FAIL fill[%0d][%0d]: got %h want %h", dir, i, data_out, exp_v);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] seq [5];
        seq = '{2'b01, 2'b11, 2'b01, 2'b00, 2'b10};
        @(negedge clk);
        rst_n = 1'b0;
        model_q = '0;
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(seq[i], 8'h33, 1'b0, 1'b0);
            exp_v = sb.pop_front();
            vectors++;
            if (data_out !== exp_v) begin
                miscompares++;
                $display("FAIL b2b[%0d]: got %h want %h", i, data_out, exp_v);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]   s;
        logic [W-1:0] d;
        for (int i = 0; i < 40; i++) begin
            s = 2'($urandom_range(0, 3));
            d = W'($urandom);
            step(s, d, 1'($urandom), 1'($urandom));
            exp_v = sb.pop_front();
            vectors++;
            if (data_out !== exp_v) begin
                miscompares++;
                $display("FAIL random[%0d]: sel %b got %h want %h", i, s, data_out, exp_v);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_load_shift_right();
        test_load_shift_left();
        test_hold();
        test_serial_fill();
        test_back_to_back();
        test_random();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
